// File: rtl/riscv_constants.sv
// Shared RISC-V front-end constants and types.
// Contents:
//   XLEN           - datapath width that the fetch-entry struct is built on
//   NOP_INSTR      - canonical NOP (addi x0, x0, 0)
//   IFETCH_STATE   - fetch-stage control states
//   ifetch_entry_t - one instruction-buffer entry {pc, instr[, misalign]}
// Optional feature macro: RISCV_IFETCH_MISALIGN_CHECK_EN adds the misalign flag
// to each buffer entry.
package riscv_constants;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IF_RUN   = 1'b0,
    IF_FLUSH = 1'b1
  } IFETCH_STATE;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
    logic            misalign;
`endif
  } ifetch_entry_t;

endpackage

// File: rtl/riscv_ifetch_fifo.sv
// Parameterised synchronous FIFO with synchronous flush.
// Used both as the instruction buffer and as the in-flight PC tag queue.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   flush       - clear all entries this cycle; same-cycle push/pop ignored
//   push        - write push_data at the tail (caller guarantees not full)
//   pop         - retire the head entry (caller guarantees not empty)
//   head_data   - head entry, read straight from storage (no bypass)
//   count       - number of valid entries
module riscv_ifetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointer increment with wrap at DEPTH (also correct for non power-of-two).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction-fetch stage: issues in-order instruction-memory requests for the
// PC stage's current address, tags them with their PC, buffers returned
// instructions and hands {pc, instr} to decode. A redirect flushes the buffer
// and drops responses still in flight for the old path.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   pc_in, redirect, fetch_stall    - PC-stage interface (stall = hold pc_in)
//   imem_req_valid/ready/addr       - request channel to instruction memory
//   imem_resp_valid/data            - in-order response beats, always accepted
//   dec_valid/ready, dec_pc/instr   - buffered instruction to decode
//   dec_misalign                    - only with RISCV_IFETCH_MISALIGN_CHECK_EN
// Optional feature macro: RISCV_IFETCH_MISALIGN_CHECK_EN. When defined,
// misaligned fetch addresses never reach memory; a flagged NOP is buffered.
module riscv_ifetch
  import riscv_constants::*;
#(
  parameter int unsigned WORD_LENGTH     = 32,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] pc_in,
  input  logic                   redirect,
  output logic                   fetch_stall,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WORD_LENGTH-1:0] imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [WORD_LENGTH-1:0] imem_resp_data,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [WORD_LENGTH-1:0] dec_pc,
  output logic [WORD_LENGTH-1:0] dec_instr
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
  ,
  output logic                   dec_misalign
`endif
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W   = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
  localparam int unsigned ENTRY_W = $bits(ifetch_entry_t);

  IFETCH_STATE      state_q, state_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]       fifo_count;
  ifetch_entry_t          fifo_head;
  ifetch_entry_t          fifo_wdata;
  logic                   fifo_push;
  logic                   fifo_pop;

  logic [WORD_LENGTH-1:0] tag_head;
  logic [OUT_W-1:0]       tag_count;

  logic credit_ok;
  logic slot_ok;
  logic local_issue;
  logic mem_accept;
  logic resp_take;

  // Credits: buffered plus in-flight entries may never exceed the buffer.
  assign credit_ok = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
  assign slot_ok   = outstanding_q < OUT_W'(MAX_OUTSTANDING);

  // A response with no tagged request in flight is ignored rather than
  // underflowing the counters.
  assign resp_take = imem_resp_valid && (tag_count != '0);

  // Issue decision.
  always_comb begin
    imem_req_valid = 1'b0;
    local_issue    = 1'b0;
    if (!reset && (state_q == IF_RUN) && !redirect && credit_ok) begin
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
      // Misaligned fetches are answered locally; waiting for an empty
      // pipeline keeps the buffered stream in program order.
      if (pc_in[1:0] != 2'b00) begin
        local_issue = (outstanding_q == '0);
      end else begin
        imem_req_valid = slot_ok;
      end
`else
      imem_req_valid = slot_ok;
`endif
    end
  end

  assign mem_accept    = imem_req_valid && imem_req_ready;
  assign fetch_stall   = !(mem_accept || local_issue);
  assign imem_req_addr = pc_in;

  // Next state, counters and buffer write.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q + OUT_W'(mem_accept) - OUT_W'(resp_take);
    drop_cnt_d    = drop_cnt_q;
    fifo_push     = 1'b0;
    fifo_wdata    = '0;
    fifo_pop      = dec_valid && dec_ready;

    case (state_q)
      IF_RUN: begin
        if (resp_take) begin
          fifo_push        = 1'b1;
          fifo_wdata.pc    = XLEN'(tag_head);
          fifo_wdata.instr = XLEN'(imem_resp_data);
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
          fifo_wdata.misalign = (tag_head[1:0] != 2'b00);
`endif
        end else if (local_issue) begin
          fifo_push        = 1'b1;
          fifo_wdata.pc    = XLEN'(pc_in);
          fifo_wdata.instr = NOP_INSTR;
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
          fifo_wdata.misalign = 1'b1;
`endif
        end
      end
      IF_FLUSH: begin
        if (resp_take && (drop_cnt_q != '0)) begin
          drop_cnt_d = drop_cnt_q - OUT_W'(1);
        end
        if (drop_cnt_d == '0) begin
          state_d = IF_RUN;
        end
      end
      default: begin
        state_d = IF_RUN;
      end
    endcase

    // Redirect wins in any state: everything still in flight is stale.
    if (redirect) begin
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      drop_cnt_d = outstanding_q - OUT_W'(resp_take);
      state_d    = (drop_cnt_d != '0) ? IF_FLUSH : IF_RUN;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IF_RUN;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // PC tags of issued-but-unreturned requests; survives redirects so stale
  // responses still retire their own tag.
  riscv_ifetch_fifo #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (mem_accept),
    .push_data (pc_in),
    .pop       (resp_take),
    .head_data (tag_head),
    .count     (tag_count)
  );

  // Instruction buffer toward decode.
  riscv_ifetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Decode view of the head entry; fields read zero when nothing is valid.
  assign dec_valid = !reset && (fifo_count != '0);
  assign dec_pc    = dec_valid ? WORD_LENGTH'(fifo_head.pc)    : '0;
  assign dec_instr = dec_valid ? WORD_LENGTH'(fifo_head.instr) : '0;
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
  assign dec_misalign = dec_valid && fifo_head.misalign;
`endif

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed self-checking bench for riscv_ifetch. The bench models the PC stage
// (advance by 4 whenever fetch_stall is low) and an in-order instruction
// memory with a configurable response latency.
module tb_riscv_ifetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        redirect;
  logic        fetch_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
  logic        dec_misalign;
  logic        s_mis;
`endif

  riscv_ifetch dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .redirect        (redirect),
    .fetch_stall     (fetch_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_pc          (dec_pc),
    .dec_instr       (dec_instr)
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
    ,
    .dec_misalign    (dec_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passed;
  int cyc;
  int acc_cnt;
  int first_acc;
  int first_dec;
  int mem_lat;

  logic [31:0] pc;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] got_pc    [$];
  logic [31:0] got_instr [$];

  logic        s_reqv, s_stall, s_decv;
  logic [31:0] s_addr, s_decpc, s_decinstr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock: sample at negedge, then update PC/memory models after posedge.
  task automatic tick();
    logic acc;
    logic [31:0] a;
    @(negedge clk);
    s_reqv     = imem_req_valid;
    s_stall    = fetch_stall;
    s_addr     = imem_req_addr;
    s_decv     = dec_valid;
    s_decpc    = dec_pc;
    s_decinstr = dec_instr;
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
    s_mis      = dec_misalign;
`endif
    acc = imem_req_valid && imem_req_ready;
    if (acc && first_acc < 0) first_acc = cyc;
    if (dec_valid && first_dec < 0) first_dec = cyc;
    if (dec_valid && dec_ready) begin
      got_pc.push_back(dec_pc);
      got_instr.push_back(dec_instr);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      acc_cnt++;
      pend_addr.push_back(s_addr);
      pend_due.push_back(cyc + mem_lat - 1);
    end
    if (!s_stall && !reset) pc = pc + 32'd4;
    redirect = 1'b0;
    pc_in    = pc;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(a);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    redirect        = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    dec_ready       = 1'b1;
    pend_addr.delete();
    pend_due.delete();
    pc    = 32'h0;
    pc_in = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    got_pc.delete();
    got_instr.delete();
    acc_cnt   = 0;
    first_acc = -1;
    first_dec = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (s_decv !== 1'b0) $display("FAIL reset_dec_valid got %b want 0", s_decv); else passed++;
    checks++; if (s_reqv !== 1'b0) $display("FAIL reset_req_valid got %b want 0", s_reqv); else passed++;
    checks++; if (s_stall !== 1'b1) $display("FAIL reset_fetch_stall got %b want 1", s_stall); else passed++;
    checks++; if (s_decpc !== 32'h0) $display("FAIL reset_dec_pc got %h want 0", s_decpc); else passed++;
    checks++; if (s_decinstr !== 32'h0) $display("FAIL reset_dec_instr got %h want 0", s_decinstr); else passed++;
  endtask

  task automatic test_zero_wait();
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (first_dec - first_acc !== 2)
      $display("FAIL zw_latency got %0d want 2", first_dec - first_acc);
    else passed++;
    checks++;
    if (got_pc.size() < 3) $display("FAIL zw_count got %0d want >=3", got_pc.size()); else passed++;
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i)) $display("FAIL zw_pc[%0d] got %h want %h", i, got_pc[i], 32'(4 * i));
      else passed++;
      checks++;
      if (got_instr[i] !== instr_of(32'(4 * i)))
        $display("FAIL zw_instr[%0d] got %h want %h", i, got_instr[i], instr_of(32'(4 * i)));
      else passed++;
    end
  endtask

  task automatic test_decode_stall();
    do_reset();
    mem_lat   = 1;
    dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (acc_cnt !== 2) $display("FAIL ds_accepts got %0d want 2", acc_cnt); else passed++;
    checks++; if (s_reqv !== 1'b0) $display("FAIL ds_req_valid got %b want 0", s_reqv); else passed++;
    checks++; if (s_stall !== 1'b1) $display("FAIL ds_stall got %b want 1", s_stall); else passed++;
    checks++; if (s_decv !== 1'b1) $display("FAIL ds_dec_valid got %b want 1", s_decv); else passed++;
    checks++; if (s_decpc !== 32'h0) $display("FAIL ds_dec_pc got %h want 0", s_decpc); else passed++;
    dec_ready = 1'b1;
    tick();
    tick();
    checks++; if (s_reqv !== 1'b1) $display("FAIL ds_resume_valid got %b want 1", s_reqv); else passed++;
    checks++; if (s_addr !== 32'h8) $display("FAIL ds_resume_addr got %h want 8", s_addr); else passed++;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (got_pc.size() < 4) $display("FAIL ds_count got %0d want >=4", got_pc.size()); else passed++;
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i)) $display("FAIL ds_pc[%0d] got %h want %h", i, got_pc[i], 32'(4 * i));
      else passed++;
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    mem_lat = 3;
    tick();
    tick();
    redirect = 1'b1;
    pc       = 32'h100;
    pc_in    = 32'h100;
    tick();
    checks++; if (s_reqv !== 1'b0) $display("FAIL rf_redirect_valid got %b want 0", s_reqv); else passed++;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (s_reqv !== 1'b0) $display("FAIL rf_flush_valid[%0d] got %b want 0", i, s_reqv); else passed++;
    end
    tick();
    checks++; if (s_reqv !== 1'b1) $display("FAIL rf_resume_valid got %b want 1", s_reqv); else passed++;
    checks++; if (s_addr !== 32'h100) $display("FAIL rf_resume_addr got %h want 100", s_addr); else passed++;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (got_pc.size() < 2) $display("FAIL rf_count got %0d want >=2", got_pc.size());
    else passed++;
    if (got_pc.size() >= 2) begin
      checks++; if (got_pc[0] !== 32'h100) $display("FAIL rf_pc0 got %h want 100", got_pc[0]); else passed++;
      checks++;
      if (got_instr[0] !== instr_of(32'h100)) $display("FAIL rf_instr0 got %h want %h", got_instr[0], instr_of(32'h100));
      else passed++;
      checks++; if (got_pc[1] !== 32'h104) $display("FAIL rf_pc1 got %h want 104", got_pc[1]); else passed++;
    end
  endtask

  task automatic test_redirect_resp_pop();
    do_reset();
    mem_lat = 1;
    tick();
    tick();
    redirect = 1'b1;
    pc       = 32'h100;
    pc_in    = 32'h100;
    tick();
    checks++; if (s_decv !== 1'b1) $display("FAIL rp_pop_valid got %b want 1", s_decv); else passed++;
    checks++; if (s_decpc !== 32'h0) $display("FAIL rp_pop_pc got %h want 0", s_decpc); else passed++;
    tick();
    checks++; if (s_decv !== 1'b0) $display("FAIL rp_empty got %b want 0", s_decv); else passed++;
    checks++; if (s_reqv !== 1'b1) $display("FAIL rp_issue got %b want 1", s_reqv); else passed++;
    checks++; if (s_addr !== 32'h100) $display("FAIL rp_addr got %h want 100", s_addr); else passed++;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (got_pc.size() < 3) $display("FAIL rp_count got %0d want >=3", got_pc.size());
    else passed++;
    if (got_pc.size() >= 3) begin
      checks++; if (got_pc[1] !== 32'h100) $display("FAIL rp_pc1 got %h want 100", got_pc[1]); else passed++;
      checks++; if (got_pc[2] !== 32'h104) $display("FAIL rp_pc2 got %h want 104", got_pc[2]); else passed++;
    end
  endtask

  task automatic test_req_ready_low();
    do_reset();
    mem_lat        = 1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_stall !== 1'b1) $display("FAIL rl_stall[%0d] got %b want 1", i, s_stall); else passed++;
      checks++; if (s_addr !== 32'h0) $display("FAIL rl_addr[%0d] got %h want 0", i, s_addr); else passed++;
    end
    checks++; if (acc_cnt !== 0) $display("FAIL rl_no_accept got %0d want 0", acc_cnt); else passed++;
    imem_req_ready = 1'b1;
    tick();
    checks++; if (s_stall !== 1'b0) $display("FAIL rl_release_stall got %b want 0", s_stall); else passed++;
    checks++; if (acc_cnt !== 1) $display("FAIL rl_one_accept got %0d want 1", acc_cnt); else passed++;
    tick();
    checks++; if (s_addr !== 32'h4) $display("FAIL rl_next_addr got %h want 4", s_addr); else passed++;
  endtask

`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    mem_lat   = 1;
    dec_ready = 1'b0;
    pc        = 32'h102;
    pc_in     = 32'h102;
    tick();
    checks++; if (s_reqv !== 1'b0) $display("FAIL ma_req_valid got %b want 0", s_reqv); else passed++;
    checks++; if (s_stall !== 1'b0) $display("FAIL ma_stall got %b want 0", s_stall); else passed++;
    tick();
    checks++; if (s_decv !== 1'b1) $display("FAIL ma_dec_valid got %b want 1", s_decv); else passed++;
    checks++; if (s_decpc !== 32'h102) $display("FAIL ma_dec_pc got %h want 102", s_decpc); else passed++;
    checks++; if (s_decinstr !== 32'h0000_0013) $display("FAIL ma_dec_instr got %h want 13", s_decinstr); else passed++;
    checks++; if (s_mis !== 1'b1) $display("FAIL ma_misalign got %b want 1", s_mis); else passed++;
    checks++; if (acc_cnt !== 0) $display("FAIL ma_no_mem got %0d want 0", acc_cnt); else passed++;
  endtask
`endif

  initial begin
    checks          = 0;
    passed          = 0;
    cyc             = 0;
    acc_cnt         = 0;
    first_acc       = -1;
    first_dec       = -1;
    mem_lat         = 1;
    pc              = 32'h0;
    pc_in           = 32'h0;
    reset           = 1'b1;
    redirect        = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    dec_ready       = 1'b1;
    test_reset();
    test_zero_wait();
    test_decode_stall();
    test_redirect_flush();
    test_redirect_resp_pop();
    test_req_ready_low();
`ifdef RISCV_IFETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/riscv_ifetch.md
Name: riscv_ifetch

Overview:
- Instruction-fetch stage directly downstream of the PC stage.
- Takes the current fetch address, issues in-order requests to instruction memory over a valid/ready channel, and tracks outstanding requests.
- Buffers returned instructions with their PCs in a small FIFO and presents {pc, instr} to decode over valid/ready.
- Back-pressures the PC stage through fetch_stall; on a redirect it flushes the FIFO and discards stale in-flight responses.

Parameters:
- WORD_LENGTH, 32, address and instruction width.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum issued-but-unreturned memory requests (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  WORD_LENGTH  current fetch address from the PC stage.
- redirect  in  1  PC stage loaded a non-sequential target (branch, jump or trap) this cycle.
- fetch_stall  out  1  PC stage must hold pc_in this cycle.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  WORD_LENGTH  request address.
- imem_resp_valid  in  1  response beat; always accepted, in order.
- imem_resp_data  in  WORD_LENGTH  fetched instruction.
- dec_valid  out  1  instruction available to decode.
- dec_ready  in  1  decode consumes the head entry.
- dec_pc  out  WORD_LENGTH  PC of the head entry.
- dec_instr  out  WORD_LENGTH  instruction of the head entry.

Behaviour:
- **Reset:** reset=1 at a posedge clears FIFO pointers and count, outstanding count, drop count and the PC tag queue, and sets state=RUN.
  - Outputs while in or just after reset: dec_valid=0, imem_req_valid=0, fetch_stall=1.
  - dec_pc and dec_instr read 0.
  - Reset mid-operation discards everything; responses arriving after reset are ignored only if drop count permits. The memory is reset alongside, so none are expected.
- **States:**
  - RUN: normal issue.
  - FLUSH: waiting for stale responses. No issue; imem_req_valid=0.
- **Issue (RUN only):** imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING) && !redirect.
  - imem_req_addr = pc_in, combinational.
- **Handshake:** a request is accepted when valid && ready. On acceptance, outstanding++ and pc_in is pushed into the in-flight PC tag queue (depth MAX_OUTSTANDING).
- **fetch_stall** = !(imem_req_valid && imem_req_ready). The PC stage advances only on an accepted request.
- **Response:** imem_resp_valid pops the PC tag queue and outstanding--.
  - In RUN, {tag, data} is written into the FIFO tail.
  - In FLUSH with drop_cnt>0, it is discarded and drop_cnt--.
  - Issue and response in the same cycle leave outstanding unchanged.
- **FIFO output:** registered output, no bypass.
  - Minimum latency from response to dec_valid is 1 cycle.
  - Head pops on dec_valid && dec_ready.
  - Simultaneous push and pop keep the count constant; a push into a full FIFO cannot occur because credits prevent it.
- **Redirect (any state):** clears the FIFO in the same cycle (dec_valid=0 next cycle; any same-cycle pop or push is discarded).
  - drop_cnt = outstanding − (imem_resp_valid ? 1 : 0), counting post-cycle in-flight requests.
  - Next state is FLUSH if drop_cnt>0, else RUN.
  - No request is issued in the redirect cycle.
- **FLUSH → RUN** when drop_cnt reaches 0, i.e. on the cycle the last stale response arrives. Issue resumes the next cycle.
- **Widths:** counters are $clog2(N+1) bits. Pointers wrap modulo FIFO_DEPTH. There is no arithmetic on PCs.

Optional Feature:
- Macro: RISCV_IFETCH_MISALIGN_CHECK_EN.
- **Defined:** adds output dec_misalign (1 bit), stored per FIFO entry = tag[1:0]!=0.
  - A request with pc_in[1:0]!=0 is not sent to memory. The entry is written directly into the FIFO with instr=32'h0000_0013 (NOP) and misalign=1.
  - It consumes a FIFO credit but not an outstanding slot.
- **Undefined:** no port; the address is issued unchanged.

Decomposition:
- Shared package riscv_constants gains:
  - IFETCH_STATE enum {IF_RUN, IF_FLUSH}.
  - NOP_INSTR = 32'h0000_0013.
  - A typedef struct for the FIFO entry {pc, instr[, misalign]}.
- One natural sub-module: riscv_ifetch_fifo, a parameterised synchronous FIFO with flush, used for both the instruction buffer and the PC tag queue.

Test Plan:
- **Reset, then zero-wait memory** (ready=1, resp 1 cycle later), pc_in 0x0, 0x4, 0x8, decode always ready → dec_pc 0x0/0x4/0x8 with matching instructions. First dec_valid 2 cycles after first accept; fetch_stall=0 in steady state.
- **Decode stalls** (dec_ready=0) with FIFO_DEPTH=2 → after 2 entries buffered, imem_req_valid=0 and fetch_stall=1. Releasing dec_ready resumes issue within 1 cycle; no instruction is lost or duplicated.
- **Redirect with 2 outstanding** to pc_in=0x100 → the next 2 responses are dropped, state=FLUSH. The first request after FLUSH has addr 0x100, and dec_pc=0x100 is the next decoded PC.
- **Redirect in the same cycle as a response and a dec pop** → FIFO empty next cycle; drop_cnt = outstanding−1, so the count is exact.
- **imem_req_ready low for 3 cycles** → fetch_stall=1 throughout, pc_in is held, and exactly one request is issued when ready rises.
- **Macro enabled, pc_in=0x102** → no memory request, dec_misalign=1, dec_instr=0x00000013, dec_pc=0x102.
